// File: rtl/matrix_pkg.sv
// Shared types and constants for the 3x3 8-bit-float matrix operand loader.
package matrix_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StStart,
        StCompute
    } state_e;

    localparam int unsigned MAT_DIM = 3;
    localparam int unsigned NBYTES  = 18;
    localparam int unsigned ELEM_W  = 8;
    localparam int unsigned NELEM   = MAT_DIM * MAT_DIM;
    localparam int unsigned FLAT_W  = NELEM * ELEM_W;

    // Operand byte layout: {sign, exp[2:0], frac[3:0]}
    localparam int unsigned SIGN_BIT = 7;
    localparam int unsigned EXP_MSB  = 6;
    localparam int unsigned EXP_LSB  = 4;
    localparam int unsigned FRAC_MSB = 3;
    localparam int unsigned FRAC_LSB = 0;

endpackage

// File: rtl/operand_regfile.sv
// 18x8 operand store: indexed byte write port, flat A/B buses (element 0 in the top byte).
module operand_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [7:0]  wdata_i,
    output logic [71:0] a_flat_o,
    output logic [71:0] b_flat_o
);
    import matrix_pkg::*;

    logic [ELEM_W-1:0] mem_q [NBYTES];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        a_flat_o = '0;
        b_flat_o = '0;
        for (int i = 0; i < int'(NELEM); i++) begin
            a_flat_o[FLAT_W-1-ELEM_W*i -: ELEM_W] = mem_q[i];
            b_flat_o[FLAT_W-1-ELEM_W*i -: ELEM_W] = mem_q[NELEM+i];
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Operand loader/sequencer for the 3x3 matrix multiplier.
// Optional framing check on in_last enabled by defining MATRIX_LOADER_FRAME_CHECK_EN.
module matrix_loader #(
    parameter int unsigned LATENCY = 9,
    parameter int unsigned NBYTES  = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [71:0] a_flat,
    output logic [71:0] b_flat,
    output logic        mm_start,
    output logic        c_valid,
    output logic        busy,
    output logic        err
);
    import matrix_pkg::*;

    localparam logic [4:0] LastIdx = 5'(NBYTES - 1);
    localparam logic [3:0] LastCnt = 4'(LATENCY - 1);

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       in_ready_q, mm_start_q, c_valid_q, busy_q;
    logic       accept, last_byte, frame_err;

    assign accept    = in_valid && in_ready_q;
    assign last_byte = (idx_q == LastIdx);

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
    assign frame_err = accept && (in_last != last_byte);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign frame_err      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    if (frame_err) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else if (last_byte) begin
                        idx_d   = '0;
                        state_d = StStart;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StCompute;
            end
            StCompute: begin
                if (cnt_q == LastCnt) begin
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
            mm_start_q <= 1'b0;
            c_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            in_ready_q <= (state_d == StLoad);
            mm_start_q <= (state_d == StStart);
            c_valid_q  <= (state_d == StCompute) && (cnt_d == LastCnt);
            busy_q     <= (state_d == StCompute);
        end
    end

    operand_regfile u_regfile (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .we_i     (accept),
        .waddr_i  (idx_q),
        .wdata_i  (in_data),
        .a_flat_o (a_flat),
        .b_flat_o (b_flat)
    );

    assign in_ready = in_ready_q;
    assign mm_start = mm_start_q;
    assign c_valid  = c_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader against a frame-level reference model.
module tb_matrix_loader;
    localparam int LAT = 9;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = '0;
    logic        in_last  = 1'b0;
    logic        in_ready, mm_start, c_valid, busy, err;
    logic [71:0] a_flat, b_flat;

    int checks = 0;
    int errors = 0;

    // Reference model: operand bytes by frame index, expected next index, sticky error.
    logic [7:0] exp_mem [18];
    int         exp_idx = 0;
    logic       exp_err = 1'b0;

    matrix_loader #(
        .LATENCY (LAT),
        .NBYTES  (18)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .a_flat   (a_flat),
        .b_flat   (b_flat),
        .mm_start (mm_start),
        .c_valid  (c_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] exp_flat(input int base);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[71-8*i -: 8] = exp_mem[base+i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 18; i++) exp_mem[i] = '0;
        exp_idx = 0;
        exp_err = 1'b0;
    endtask

    // Present one byte after `gaps` idle cycles; update the model and check the result.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gaps,
                             output logic done);
        logic fe;
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            tick();
            checks++;
            if (in_ready !== 1'b1 || mm_start !== 1'b0) begin
                errors++;
                $display("FAIL gap_idle: ready=%b start=%b, want 1/0", in_ready, mm_start);
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_mem[exp_idx] = d;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
        fe = (last != (exp_idx == 17));
`else
        fe = 1'b0;
`endif
        done = (exp_idx == 17) && !fe;
        if (fe) exp_err = 1'b1;
        exp_idx = (fe || exp_idx == 17) ? 0 : exp_idx + 1;
        checks++;
        if (mm_start !== done || in_ready !== !done || busy !== 1'b0) begin
            errors++;
            $display("FAIL byte_handshake: start=%b ready=%b busy=%b, want %b/%b/0",
                     mm_start, in_ready, busy, done, !done);
        end
        checks++;
        if (a_flat !== exp_flat(0) || b_flat !== exp_flat(9)) begin
            errors++;
            $display("FAIL byte_regs: a=%h b=%h, want a=%h b=%h",
                     a_flat, b_flat, exp_flat(0), exp_flat(9));
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL byte_err: err=%b, want %b", err, exp_err);
        end
    endtask

    // Called at the sample right after byte 17 is accepted (edge N); walks N..N+LAT+1.
    task automatic finish_frame(input logic hold, input int abort_at);
        for (int k = 0; k <= LAT + 1; k++) begin
            checks++;
            if (mm_start !== (k == 0) || c_valid !== (k == LAT) ||
                busy !== (k >= 1 && k <= LAT) || in_ready !== (k == LAT + 1)) begin
                errors++;
                $display("FAIL frame_timing k=%0d: start=%b cvalid=%b busy=%b ready=%b, want %b/%b/%b/%b",
                         k, mm_start, c_valid, busy, in_ready, (k == 0), (k == LAT),
                         (k >= 1 && k <= LAT), (k == LAT + 1));
            end
            checks++;
            if (a_flat !== exp_flat(0) || b_flat !== exp_flat(9)) begin
                errors++;
                $display("FAIL frame_regs k=%0d: a=%h b=%h, want a=%h b=%h",
                         k, a_flat, b_flat, exp_flat(0), exp_flat(9));
            end
            if (k == abort_at) begin
                in_valid = 1'b0;
                rst_n    = 1'b0;
                tick();
                rst_n = 1'b1;
                model_clear();
                checks++;
                if (busy !== 1'b0 || c_valid !== 1'b0 || in_ready !== 1'b1 ||
                    mm_start !== 1'b0 || a_flat !== 72'h0 || b_flat !== 72'h0) begin
                    errors++;
                    $display("FAIL abort_state: busy=%b cvalid=%b ready=%b start=%b a=%h b=%h, want 0/0/1/0/0/0",
                             busy, c_valid, in_ready, mm_start, a_flat, b_flat);
                end
                for (int j = 0; j < LAT + 2; j++) begin
                    tick();
                    checks++;
                    if (c_valid !== 1'b0 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_quiet j=%0d: cvalid=%b busy=%b, want 0/0",
                                 j, c_valid, busy);
                    end
                end
                return;
            end
            if (k == LAT + 1) break;
            in_valid = hold;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, input logic hold);
        logic done;
        for (int i = 0; i < 18; i++)
            send_byte(8'($urandom), (i == 17), $urandom_range(max_gap, 0), done);
        finish_frame(hold, -1);
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        model_clear();
        checks++;
        if (in_ready !== 1'b1 || mm_start !== 1'b0 || c_valid !== 1'b0 ||
            busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b start=%b cvalid=%b busy=%b err=%b, want 1/0/0/0/0",
                     in_ready, mm_start, c_valid, busy, err);
        end
        checks++;
        if (a_flat !== 72'h0 || b_flat !== 72'h0) begin
            errors++;
            $display("FAIL reset_regs: a=%h b=%h, want 0", a_flat, b_flat);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal(input int gaps);
        logic done;
        for (int i = 0; i < 18; i++) send_byte(8'(i + 1), (i == 17), gaps, done);
        checks++;
        if (a_flat !== 72'h010203040506070809 || b_flat !== 72'h0A0B0C0D0E0F101112) begin
            errors++;
            $display("FAIL nominal_regs gaps=%0d: a=%h b=%h, want 010203040506070809/0A0B0C0D0E0F101112",
                     gaps, a_flat, b_flat);
        end
        finish_frame(1'b0, -1);
    endtask

    task automatic test_back_to_back();
        send_frame(0, 1'b1);
        send_frame(0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        logic done;
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0, $urandom_range(1, 0), done);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        checks++;
        if (a_flat !== 72'h0 || b_flat !== 72'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_clear: a=%h b=%h ready=%b, want 0/0/1", a_flat, b_flat, in_ready);
        end
        for (int i = 0; i < 18; i++) send_byte(8'hFF, (i == 17), 0, done);
        checks++;
        if (a_flat !== {9{8'hFF}} || b_flat !== {9{8'hFF}}) begin
            errors++;
            $display("FAIL midreset_regs: a=%h b=%h, want all FF", a_flat, b_flat);
        end
        finish_frame(1'b0, -1);
    endtask

    task automatic test_reset_compute();
        logic done;
        for (int i = 0; i < 18; i++) send_byte(8'($urandom), (i == 17), 0, done);
        finish_frame(1'b0, 3);
        send_frame(1, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) send_frame(2, 1'($urandom));
    endtask

    task automatic test_frame_error();
        logic done;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), (i == 5), 0, done);
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (err !== 1'b1 || mm_start !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL frame_err_hold: err=%b start=%b ready=%b, want 1/0/1",
                         err, mm_start, in_ready);
            end
        end
        send_frame(0, 1'b0);
`else
        for (int i = 0; i < 18; i++) send_byte(8'($urandom), (i == 5), 0, done);
        checks++;
        if (err !== 1'b0 || mm_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_off: err=%b start=%b, want 0/1", err, mm_start);
        end
        finish_frame(1'b0, -1);
`endif
    endtask

    initial begin
        test_reset();
        test_nominal(0);
        test_nominal(1);
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_compute();
        test_random();
        test_frame_error();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream operand stage for the 3x3 8-bit-float matrix multiplier. Accepts a byte stream of 18 operand bytes (A row-major, then B row-major) over a valid/ready handshake, holds them on flat parallel buses wired to the multiplier's A/B inputs, and issues a one-cycle start pulse. It then times the multiplier's fixed compute window and flags when the C outputs are valid to sample.

## Interface

Parameters:
- `LATENCY`, default 9: cycles from `mm_start` to stable multiplier outputs. Legal range 1..15.
- `NBYTES`, default 18: operand bytes per frame (9 A, then 9 B). Fixed; not for override.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: upstream byte valid.
- `in_data`, in, 8: operand byte in the 8-bit float format {sign, exp[2:0], frac[3:0]}.
- `in_last`, in, 1: marks the final byte of a frame.
- `in_ready`, out, 1: loader can accept a byte.
- `a_flat`, out, 72: A operands; A00 occupies [71:64] and A22 occupies [7:0].
- `b_flat`, out, 72: B operands, same packing as `a_flat`.
- `mm_start`, out, 1: one-cycle pulse; the multiplier begins its sequence.
- `c_valid`, out, 1: one-cycle pulse; the multiplier's C outputs are final.
- `busy`, out, 1: high in COMPUTE.
- `err`, out, 1: sticky framing error. Exists only with `MATRIX_LOADER_FRAME_CHECK_EN`; see Configuration.

## Operation

- **States:** LOAD, START, COMPUTE.
  - LOAD → START when byte index 17 is accepted.
  - START → COMPUTE unconditionally after one cycle.
  - COMPUTE → LOAD when the counter reaches `LATENCY`-1.
- **Byte acceptance:** a byte is accepted on a `clk` edge with `in_valid && in_ready`.
- **Byte index:** a 5-bit counter, 0..17.
  - Indices 0..8 write A elements in row-major order (A00, A01, …, A22).
  - Indices 9..17 write B elements (B00, …, B22).
  - The counter wraps to 0 after index 17.
- **`in_ready`:** high in LOAD only; low in START and COMPUTE.
- **Operand registers:** written only on accepted bytes. Each byte is stored unchanged (no format conversion).
  - Operands stay stable from the START cycle through the end of COMPUTE.
  - Each A element is overwritten individually as the next frame's byte arrives.
- **`mm_start`:** high exactly during the START cycle.
- **Compute counter:** 4 bits, cleared in START, incremented each COMPUTE cycle.
- **`c_valid`:** high on the final COMPUTE cycle (counter = `LATENCY`-1). The next cycle is LOAD.
- **`in_last`:** ignored when `MATRIX_LOADER_FRAME_CHECK_EN` is not defined.
- **Reset (`rst_n`=0 at a `clk` edge):**
  - State → LOAD; byte index → 0; compute counter → 0.
  - `a_flat` and `b_flat` → 0.
  - `mm_start`, `c_valid`, `busy` and `err` → 0; `in_ready` → 1 from the first cycle after reset.
  - Reset mid-frame discards any partial frame. Reset during COMPUTE aborts the frame with no `c_valid`.

## Timing

- **Back-to-back bytes:** accepted one per cycle in LOAD.
- **Start timing:** byte 17 accepted at edge N. START covers cycle N..N+1, so `mm_start` is high from edge N to edge N+1.
- **Valid timing:** COMPUTE runs `LATENCY` cycles. `c_valid` is high in the cycle following edge N+`LATENCY`.
- **Frame turnaround:** the first byte of the next frame is accepted at earliest `LATENCY`+2 edges after byte 17.
- **`in_valid` deassertion:** allowed mid-frame. The index holds and there is no timeout.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- **`MATRIX_LOADER_FRAME_CHECK_EN` defined:**
  - A frame error is either `in_last`=1 on an accepted byte with index ≠ 17, or `in_last`=0 on the accepted index-17 byte.
  - On a frame error, set `err` (sticky until reset) and return the byte index to 0. No START follows.
  - The errant byte is still written to its operand register.
- **Not defined:**
  - `in_last` is ignored.
  - `err` is tied to 0.

## Structure

- **Shared package (`matrix_pkg`):**
  - State enum (LOAD/START/COMPUTE).
  - Constant `MAT_DIM`=3.
  - Constant `NBYTES`=18.
  - Element width 8.
  - Field positions of the float format: sign bit 7, exp [6:4], frac [3:0].
- **Sub-module:** one, `operand_regfile`. It holds 18×8 registers with an indexed write port and the flat A/B output packing.
- **Top-level contents:** FSM, byte index, compute counter and the handshake.

## Test plan

- **Nominal frame:** after reset, stream bytes 0x01..0x12 with no gaps. Expect `a_flat`=0x010203040506070809 and `b_flat`=0x0A0B0C0D0E0F101112. `mm_start` pulses one cycle after the last byte; `c_valid` pulses 9 cycles after `mm_start`.
- **Gapped input:** toggle `in_valid` every other cycle across a frame. Expect the same register contents and exactly one `mm_start`.
- **Backpressure:** hold `in_valid`=1 during COMPUTE. Expect `in_ready`=0, no register changes, and the next frame's byte 0 accepted in the cycle after `c_valid`.
- **Reset mid-frame:** assert `rst_n`=0 after 7 bytes, then send a full frame of 0xFF. Expect all operands 0xFF, with only one `mm_start`.
- **Reset in COMPUTE:** assert `rst_n`=0 three cycles after `mm_start`. Expect no `c_valid`, `busy`=0 and `in_ready`=1.
- **Framing error (`MATRIX_LOADER_FRAME_CHECK_EN`):** assert `in_last` on byte 5. Expect `err`=1, no `mm_start`, and index 0 for the next byte. Without the macro, the same stimulus gives `err`=0 and a normal frame completion after 18 bytes.
